// File: rtl/vdp_io_sequencer.sv
// vdp_io_sequencer
//   Turns Z80 I/O cycles on VDP ports $98-$9B into single REQ/ACK
//   transactions on the VDP CPU port. Writes are queued in a small FIFO so
//   the CPU only waits when the FIFO is full. Reads hold the CPU in WAIT
//   until every earlier write has drained and the VDP has returned data.
//
// Parameters
//   FIFO_DEPTH   write FIFO entries (power of two, >= 2)
//   ACK_TIMEOUT  cycles a request may stay outstanding before it is dropped
//
// Ports
//   clk_w, reset_n_w    clock, asynchronous active-low reset
//   csr_n, csw_n        filtered CPU read/write strobes (asynchronous)
//   port_sel, cpu_data  VDP port number and write data of the CPU cycle
//   vdp_dbi, vdp_ack    VDP read data and one-cycle completion pulse
//   vdp_req, vdp_wrt,
//   vdp_adr, vdp_dbo    outstanding request (held until ack or timeout)
//   rd_data             last read result
//   cpu_wait_n          Z80 WAIT, active-low
//   fifo_level          number of queued writes
//   overflow            sticky: a write was lost
//   timeout_err         sticky: a request was abandoned
module vdp_io_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                          clk_w,
  input  logic                          reset_n_w,
  input  logic                          csr_n,
  input  logic                          csw_n,
  input  logic [1:0]                    port_sel,
  input  logic [7:0]                    cpu_data,
  input  logic [7:0]                    vdp_dbi,
  input  logic                          vdp_ack,
  output logic                          vdp_req,
  output logic                          vdp_wrt,
  output logic [1:0]                    vdp_adr,
  output logic [7:0]                    vdp_dbo,
  output logic [7:0]                    rd_data,
  output logic                          cpu_wait_n,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_RD_REQ
  } state_t;

  state_t          state;
  logic [TW-1:0]   tmo_cnt;

  logic            csr_s1, csr_s2, csr_s3;
  logic            csw_s1, csw_s2, csw_s3;

  logic            wr_pending;
  logic            rd_pending;
  logic [1:0]      rd_port;

  logic [9:0]      fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [9:0]      fifo_head;

  logic            rd_start, wr_start;
  logic            rd_start_ok, wr_start_ok;
  logic            fifo_empty, fifo_full;
  logic            pop, push, slot_free, wr_drop;
  logic            tmo_hit, rd_done;
  logic            wr_pending_nxt, rd_pending_nxt;

  // Start events: synchronised strobe has just gone low.
  always_comb begin
    rd_start    = csr_s3 & ~csr_s2;
    wr_start    = csw_s3 & ~csw_s2;
    // Both strobes starting together cannot be a real CPU cycle; drop both.
    rd_start_ok = rd_start & ~wr_start;
    wr_start_ok = wr_start & ~rd_start;

    fifo_empty  = (wr_ptr == rd_ptr);
    fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    fifo_head   = fifo_mem[rd_ptr[AW-1:0]];

    pop         = (state == ST_IDLE) && !fifo_empty;
    // A pop on the same edge frees the slot the push needs.
    slot_free   = !fifo_full || pop;
    push        = (wr_start_ok || wr_pending) && slot_free;
    // Writer gave up (strobe high again) before a slot opened.
    wr_drop     = wr_pending && !slot_free && csw_s2;

    tmo_hit     = (state != ST_IDLE) && !vdp_ack &&
                  (tmo_cnt == TW'(ACK_TIMEOUT - 1));
    rd_done     = (state == ST_RD_REQ) && (vdp_ack || tmo_hit);

    wr_pending_nxt = wr_pending;
    if (push || wr_drop)
      wr_pending_nxt = 1'b0;
    else if (wr_start_ok)
      wr_pending_nxt = 1'b1;

    rd_pending_nxt = rd_pending;
    if (rd_start_ok)
      rd_pending_nxt = 1'b1;
    else if (rd_done)
      rd_pending_nxt = 1'b0;
  end

  // Stage: strobe synchronisers, pending flags, WAIT, FIFO pointers/level
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      csr_s1     <= 1'b1;
      csr_s2     <= 1'b1;
      csr_s3     <= 1'b1;
      csw_s1     <= 1'b1;
      csw_s2     <= 1'b1;
      csw_s3     <= 1'b1;
      wr_pending <= 1'b0;
      rd_pending <= 1'b0;
      rd_port    <= 2'd0;
      cpu_wait_n <= 1'b1;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      csr_s1     <= csr_n;
      csr_s2     <= csr_s1;
      csr_s3     <= csr_s2;
      csw_s1     <= csw_n;
      csw_s2     <= csw_s1;
      csw_s3     <= csw_s2;
      wr_pending <= wr_pending_nxt;
      rd_pending <= rd_pending_nxt;
      cpu_wait_n <= !(wr_pending_nxt || rd_pending_nxt);
      if (rd_start_ok)
        rd_port <= port_sel;
      if (wr_drop)
        overflow <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Stage: FIFO storage (port_sel/cpu_data are stable for the whole CPU cycle)
  always_ff @(posedge clk_w) begin
    if (push)
      fifo_mem[wr_ptr[AW-1:0]] <= {port_sel, cpu_data};
  end

  // Stage: dispatcher FSM with registered VDP request outputs
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      vdp_req     <= 1'b0;
      vdp_wrt     <= 1'b0;
      vdp_adr     <= 2'd0;
      vdp_dbo     <= 8'h00;
      rd_data     <= 8'hFF;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Queued writes go first so a read never overtakes them.
          if (!fifo_empty) begin
            vdp_adr <= fifo_head[9:8];
            vdp_dbo <= fifo_head[7:0];
            vdp_wrt <= 1'b1;
            vdp_req <= 1'b1;
            tmo_cnt <= '0;
            state   <= ST_WR_REQ;
          end else if (rd_pending) begin
            vdp_adr <= rd_port;
            vdp_wrt <= 1'b0;
            vdp_req <= 1'b1;
            tmo_cnt <= '0;
            state   <= ST_RD_REQ;
          end
        end
        ST_WR_REQ, ST_RD_REQ: begin
          if (vdp_ack) begin
            vdp_req <= 1'b0;
            state   <= ST_IDLE;
            if (state == ST_RD_REQ)
              rd_data <= vdp_dbi;
          end else if (tmo_hit) begin
            // Abandon: a write is lost, a read returns all-ones.
            vdp_req     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
            if (state == ST_RD_REQ)
              rd_data <= 8'hFF;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: begin
          vdp_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_io_sequencer.sv
module tb_vdp_io_sequencer;

  logic       clk_w = 1'b0;
  logic       reset_n_w = 1'b0;
  logic       csr_n = 1'b1;
  logic       csw_n = 1'b1;
  logic [1:0] port_sel = 2'd0;
  logic [7:0] cpu_data = 8'h00;
  logic [7:0] vdp_dbi = 8'h00;
  logic       vdp_ack;
  logic       vdp_req;
  logic       vdp_wrt;
  logic [1:0] vdp_adr;
  logic [7:0] vdp_dbo;
  logic [7:0] rd_data;
  logic       cpu_wait_n;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       timeout_err;

  int checks = 0;
  int failures = 0;

  // VDP responder controls and log of acknowledged requests
  bit         auto_ack = 1'b0;
  int         ack_delay = 1;
  int         ack_cnt = 0;
  logic       log_wrt [64];
  logic [1:0] log_adr [64];
  logic [7:0] log_dbo [64];
  int         log_n = 0;

  // Length of the most recent completed vdp_req pulse, in cycles
  int run_len = 0;
  int last_len = 0;

  vdp_io_sequencer #(.FIFO_DEPTH(4), .ACK_TIMEOUT(255)) dut (
    .clk_w       (clk_w),
    .reset_n_w   (reset_n_w),
    .csr_n       (csr_n),
    .csw_n       (csw_n),
    .port_sel    (port_sel),
    .cpu_data    (cpu_data),
    .vdp_dbi     (vdp_dbi),
    .vdp_ack     (vdp_ack),
    .vdp_req     (vdp_req),
    .vdp_wrt     (vdp_wrt),
    .vdp_adr     (vdp_adr),
    .vdp_dbo     (vdp_dbo),
    .rd_data     (rd_data),
    .cpu_wait_n  (cpu_wait_n),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk_w = ~clk_w;

  always @(posedge clk_w) begin
    if (vdp_req === 1'b1)
      run_len <= run_len + 1;
    else begin
      if (run_len != 0)
        last_len <= run_len;
      run_len <= 0;
    end
  end

  // VDP model: acks a request ack_delay cycles after it is seen
  initial begin
    vdp_ack = 1'b0;
    forever begin
      @(posedge clk_w);
      #2;
      if (vdp_ack) begin
        vdp_ack = 1'b0;
        ack_cnt = 0;
      end else if (auto_ack && vdp_req === 1'b1) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          vdp_ack = 1'b1;
          ack_cnt = 0;
          if (log_n < 64) begin
            log_wrt[log_n] = vdp_wrt;
            log_adr[log_n] = vdp_adr;
            log_dbo[log_n] = vdp_dbo;
          end
          log_n++;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=no_finish required=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_w);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr_cycle(input logic [1:0] p, input logic [7:0] d);
    port_sel = p;
    cpu_data = d;
    csw_n = 1'b0;
    ticks(3);
    csw_n = 1'b1;
    ticks(3);
  endtask

  initial begin
    int n;
    int base;
    int seen;

    // ---------------- reset state ----------------
    ticks(3);
    chk("rst_req",   32'(vdp_req), 0);
    chk("rst_wrt",   32'(vdp_wrt), 0);
    chk("rst_adr",   32'(vdp_adr), 0);
    chk("rst_dbo",   32'(vdp_dbo), 0);
    chk("rst_rd",    32'(rd_data), 'hFF);
    chk("rst_wait",  32'(cpu_wait_n), 1);
    chk("rst_lvl",   32'(fifo_level), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_tmo",   32'(timeout_err), 0);
    reset_n_w = 1'b1;
    ticks(3);

    // ---------------- single write, port 1, 5A, ack after 2 cycles ----------------
    auto_ack = 1'b1;
    ack_delay = 2;
    port_sel = 2'd1;
    cpu_data = 8'h5A;
    csw_n = 1'b0;
    ticks(2);
    chk("w1_lvl_e1", 32'(fifo_level), 0);
    chk("w1_req_e1", 32'(vdp_req), 0);
    tick();
    chk("w1_lvl_e2", 32'(fifo_level), 1);
    chk("w1_req_e2", 32'(vdp_req), 0);
    chk("w1_wait_e2", 32'(cpu_wait_n), 1);
    tick();
    chk("w1_req_e3", 32'(vdp_req), 1);
    chk("w1_wrt_e3", 32'(vdp_wrt), 1);
    chk("w1_adr_e3", 32'(vdp_adr), 1);
    chk("w1_dbo_e3", 32'(vdp_dbo), 'h5A);
    chk("w1_lvl_e3", 32'(fifo_level), 0);
    tick();
    chk("w1_req_e4", 32'(vdp_req), 1);
    tick();
    chk("w1_req_e5", 32'(vdp_req), 0);
    csw_n = 1'b1;
    ticks(3);
    chk("w1_logged", 32'(log_n), 1);

    // ---------------- read, FIFO empty, 1-cycle ack ----------------
    ack_delay = 1;
    vdp_dbi = 8'h3C;
    port_sel = 2'd2;
    csr_n = 1'b0;
    ticks(3);
    chk("r1_wait_e2", 32'(cpu_wait_n), 0);
    chk("r1_req_e2", 32'(vdp_req), 0);
    tick();
    chk("r1_req_e3", 32'(vdp_req), 1);
    chk("r1_wrt_e3", 32'(vdp_wrt), 0);
    chk("r1_adr_e3", 32'(vdp_adr), 2);
    chk("r1_wait_e3", 32'(cpu_wait_n), 0);
    tick();
    chk("r1_req_e4", 32'(vdp_req), 0);
    chk("r1_data_e4", 32'(rd_data), 'h3C);
    chk("r1_wait_e4", 32'(cpu_wait_n), 1);
    csr_n = 1'b1;
    ticks(3);

    // ---------------- fill FIFO with ack withheld, then a write that waits ----------------
    // The first write is popped into the request, so five writes leave
    // four queued and the sixth has to wait.
    auto_ack = 1'b0;
    for (int i = 1; i <= 5; i++) wr_cycle(2'd0, 8'(i));
    chk("fill_lvl", 32'(fifo_level), 4);
    chk("fill_req", 32'(vdp_req), 1);
    chk("fill_dbo", 32'(vdp_dbo), 'h01);
    chk("fill_wait", 32'(cpu_wait_n), 1);
    cpu_data = 8'h06;
    csw_n = 1'b0;
    ticks(3);
    chk("full_wait_lo", 32'(cpu_wait_n), 0);
    chk("full_lvl", 32'(fifo_level), 4);
    auto_ack = 1'b1;
    tick();
    chk("full_ack_req", 32'(vdp_req), 0);
    chk("full_ack_wait", 32'(cpu_wait_n), 0);
    tick();
    chk("full_push_wait", 32'(cpu_wait_n), 1);
    chk("full_push_lvl", 32'(fifo_level), 4);
    chk("full_push_req", 32'(vdp_req), 1);
    chk("full_push_dbo", 32'(vdp_dbo), 'h02);
    csw_n = 1'b1;
    n = 0;
    while (log_n < 8 && n < 100) begin tick(); n++; end
    chk("drain_bound", 32'(n < 100), 1);
    ticks(2);
    chk("drain_lvl", 32'(fifo_level), 0);
    chk("drain_req", 32'(vdp_req), 0);
    chk("drain_ovf", 32'(overflow), 0);
    for (int i = 0; i < 6; i++) begin
      chk("order_dbo", 32'(log_dbo[2+i]), 32'(i + 1));
      chk("order_wrt", 32'(log_wrt[2+i]), 1);
    end

    // ---------------- three queued writes then a read ----------------
    auto_ack = 1'b0;
    wr_cycle(2'd3, 8'hA1);
    wr_cycle(2'd3, 8'hA2);
    wr_cycle(2'd3, 8'hA3);
    chk("q3_lvl", 32'(fifo_level), 2);
    port_sel = 2'd1;
    csr_n = 1'b0;
    ticks(3);
    chk("q3_rd_wait", 32'(cpu_wait_n), 0);
    vdp_dbi = 8'h9F;
    auto_ack = 1'b1;
    n = 0;
    while (cpu_wait_n !== 1'b1 && n < 100) begin tick(); n++; end
    chk("q3_bound", 32'(n < 100), 1);
    chk("q3_rd_data", 32'(rd_data), 'h9F);
    chk("q3_log_n", 32'(log_n), 12);
    for (int i = 0; i < 3; i++) begin
      chk("q3_wr_wrt", 32'(log_wrt[8+i]), 1);
      chk("q3_wr_dbo", 32'(log_dbo[8+i]), 32'('hA1 + i));
    end
    chk("q3_rd_wrt", 32'(log_wrt[11]), 0);
    chk("q3_rd_adr", 32'(log_adr[11]), 1);
    csr_n = 1'b1;
    ticks(3);

    // ---------------- write timeout, next entry dispatches, read timeout ----------------
    auto_ack = 1'b0;
    wr_cycle(2'd2, 8'h77);
    wr_cycle(2'd2, 8'h78);
    chk("to_err_before", 32'(timeout_err), 0);
    chk("to_req_77", 32'(vdp_req), 1);
    chk("to_dbo_77", 32'(vdp_dbo), 'h77);
    n = 0;
    while (vdp_req === 1'b1 && n < 400) begin tick(); n++; end
    chk("to_bound1", 32'(n < 400), 1);
    chk("to_err_set", 32'(timeout_err), 1);
    tick();
    chk("to_len1", 32'(last_len), 255);
    chk("to_next_req", 32'(vdp_req), 1);
    chk("to_next_dbo", 32'(vdp_dbo), 'h78);
    chk("to_next_lvl", 32'(fifo_level), 0);
    n = 0;
    while (vdp_req === 1'b1 && n < 400) begin tick(); n++; end
    chk("to_bound2", 32'(n < 400), 1);
    tick();
    port_sel = 2'd3;
    csr_n = 1'b0;
    ticks(3);
    chk("to_rd_wait", 32'(cpu_wait_n), 0);
    n = 0;
    while (cpu_wait_n !== 1'b1 && n < 400) begin tick(); n++; end
    chk("to_rd_bound", 32'(n < 400), 1);
    chk("to_rd_data", 32'(rd_data), 'hFF);
    chk("to_rd_req", 32'(vdp_req), 0);
    tick();
    chk("to_rd_len", 32'(last_len), 255);
    csr_n = 1'b1;
    ticks(3);

    // ---------------- overflow: writer gives up while waiting ----------------
    for (int i = 0; i < 5; i++) wr_cycle(2'd0, 8'('hB0 + i));
    chk("ov_lvl", 32'(fifo_level), 4);
    cpu_data = 8'hBF;
    csw_n = 1'b0;
    ticks(3);
    chk("ov_wait_lo", 32'(cpu_wait_n), 0);
    chk("ov_flag_before", 32'(overflow), 0);
    csw_n = 1'b1;
    ticks(3);
    chk("ov_flag", 32'(overflow), 1);
    chk("ov_wait_rel", 32'(cpu_wait_n), 1);
    chk("ov_lvl_kept", 32'(fifo_level), 4);
    base = log_n;
    auto_ack = 1'b1;
    n = 0;
    while ((fifo_level != 3'd0 || vdp_req === 1'b1) && n < 100) begin tick(); n++; end
    chk("ov_bound", 32'(n < 100), 1);
    ticks(2);
    chk("ov_drained", 32'(log_n - base), 5);
    chk("ov_last_dbo", 32'(log_dbo[base+4]), 'hB4);
    chk("ov_sticky", 32'(overflow), 1);

    // ---------------- read and write strobes together ----------------
    base = log_n;
    csr_n = 1'b0;
    csw_n = 1'b0;
    ticks(6);
    chk("both_lvl", 32'(fifo_level), 0);
    chk("both_req", 32'(vdp_req), 0);
    chk("both_wait", 32'(cpu_wait_n), 1);
    csr_n = 1'b1;
    csw_n = 1'b1;
    ticks(4);
    chk("both_req_after", 32'(vdp_req), 0);
    chk("both_no_xfer", 32'(log_n), 32'(base));

    // ---------------- reset with a request outstanding and 2 queued ----------------
    auto_ack = 1'b0;
    wr_cycle(2'd1, 8'hC1);
    wr_cycle(2'd1, 8'hC2);
    wr_cycle(2'd1, 8'hC3);
    chk("mr_lvl", 32'(fifo_level), 2);
    chk("mr_req", 32'(vdp_req), 1);
    reset_n_w = 1'b0;
    #2;
    chk("mr_rst_req",  32'(vdp_req), 0);
    chk("mr_rst_wrt",  32'(vdp_wrt), 0);
    chk("mr_rst_adr",  32'(vdp_adr), 0);
    chk("mr_rst_dbo",  32'(vdp_dbo), 0);
    chk("mr_rst_rd",   32'(rd_data), 'hFF);
    chk("mr_rst_wait", 32'(cpu_wait_n), 1);
    chk("mr_rst_lvl",  32'(fifo_level), 0);
    chk("mr_rst_ovf",  32'(overflow), 0);
    chk("mr_rst_tmo",  32'(timeout_err), 0);
    @(negedge clk_w);
    reset_n_w = 1'b1;
    auto_ack = 1'b1;
    base = log_n;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vdp_req !== 1'b0) seen = 1;
    end
    chk("mr_no_req", 32'(seen), 0);
    chk("mr_no_xfer", 32'(log_n), 32'(base));
    chk("mr_lvl_after", 32'(fifo_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
